store_buffer: RTL and testbench

//  Posted-write buffer between the pipeline's memory stage (MemWriteM/DataAdrM/WriteDataM) and data memory.

---
 rtl/store_buffer_pkg.sv | 25 ++
 rtl/store_buffer_fwd_select.sv | 36 +++
 rtl/store_buffer.sv | 126 ++++++++++++
 tb/tb_store_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and width helpers for the posted-write store buffer.
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   // One buffered store. v marks an occupied slot.
   typedef struct packed {
      logic             v;
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

   // Pointer width for a circular buffer of the given depth.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counter width: must be able to hold the value depth itself.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/store_buffer_fwd_select.sv
// Youngest-match selector for store-to-load forwarding. Walks the occupied
// window from the oldest entry (rd_ptr) towards the youngest (wr_ptr-1);
// later matches override earlier ones so the youngest hit wins.
module sb_fwd_select
   import store_buffer_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH,
   localparam int PW    = ptr_w(DEPTH)
) (
   input  logic [DEPTH-1:0] match,
   input  logic [PW-1:0]    rd_ptr,
   input  logic [PW-1:0]    wr_ptr,
   input  logic             full,
   output logic             hit,
   output logic [PW-1:0]    idx
);

   logic [PW-1:0] used;
   logic [PW-1:0] pos;

   // Rotate-priority scan: oldest first, youngest last so it takes priority.
   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      pos  = '0;
      used = wr_ptr - rd_ptr;
      for (int k = 0; k < DEPTH; k++) begin
         pos = rd_ptr + PW'(k);
         if ((full || (PW'(k) < used)) && match[pos]) begin
            hit = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues stores from the memory stage, drains them
// in order to a valid/ready memory port and forwards the youngest matching
// buffered store to a load (word granularity).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. st_ready depends only on registered occupancy; mem_valid, mem_addr
// and mem_wdata come straight from registers and hold while mem_ready is 0.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter  int DEPTH = SB_DEPTH,
   parameter  int AW    = SB_AW,
   parameter  int DW    = SB_DW,
   localparam int PW    = ptr_w(DEPTH),
   localparam int CW    = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   output logic          st_ready,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hit,
   output logic [DW-1:0] ld_data,
   output logic          mem_valid,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   output logic [CW-1:0] count,
   output logic          empty
);

   sb_entry_t     entries_q [DEPTH];
   sb_entry_t     entries_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic             push;
   logic             pop;
   logic             full;
   logic [DEPTH-1:0] match;
   logic             fwd_hit;
   logic [PW-1:0]    fwd_idx;

   // Handshake and status outputs, all derived from registered state.
   always_comb begin
      full      = (count_q == CW'(DEPTH));
      st_ready  = !full;
      empty     = (count_q == '0);
      mem_valid = !empty;
      mem_addr  = entries_q[rd_ptr_q].addr;
      mem_wdata = entries_q[rd_ptr_q].data;
      count     = count_q;
      push      = st_valid && st_ready;
      pop       = mem_valid && mem_ready;
   end

   // Next state: retire the head on pop, write the tail on push. When full no
   // push is admitted, so the written slot is never the one being popped.
   always_comb begin
      entries_d = entries_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (pop) begin
         entries_d[rd_ptr_q].v = 1'b0;
         rd_ptr_d              = rd_ptr_q + PW'(1);
      end
      if (push) begin
         entries_d[wr_ptr_q].v    = 1'b1;
         entries_d[wr_ptr_q].addr = st_addr;
         entries_d[wr_ptr_q].data = st_data;
         wr_ptr_d                 = wr_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards every pending store immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         entries_q <= entries_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Word-address compare of the load against every occupied entry.
   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = entries_q[i].v && (entries_q[i].addr[AW-1:2] == ld_addr[AW-1:2]);
      end
   end

   sb_fwd_select #(
      .DEPTH (DEPTH)
   ) u_fwd_select (
      .match  (match),
      .rd_ptr (rd_ptr_q),
      .wr_ptr (wr_ptr_q),
      .full   (full),
      .hit    (fwd_hit),
      .idx    (fwd_idx)
   );

   // Forwarded load data; zero when nothing matches.
   always_comb begin
      ld_hit  = fwd_hit;
      ld_data = fwd_hit ? entries_q[fwd_idx].data : '0;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, checked
// against a queue-based model of the buffer and a drain-order scoreboard.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [2:0]  count;
   logic        empty;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } st_t;

   st_t         mq[$];     // model contents, oldest first
   logic [63:0] exp_q[$];  // expected memory writes {addr, data}
   int          checks = 0;
   int          errors = 0;

   store_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_ready  (st_ready),
      .ld_addr   (ld_addr),
      .ld_hit    (ld_hit),
      .ld_data   (ld_data),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .count     (count),
      .empty     (empty)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // compare all observable state with the model
   task automatic check_state();
      logic        hit;
      logic [31:0] data;
      hit  = 1'b0;
      data = 32'h0;
      chk("count", 32'(count), 32'(mq.size()));
      chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("mem_valid", 32'(mem_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("mem_addr", mem_addr, mq[0].a);
         chk("mem_wdata", mem_wdata, mq[0].d);
      end
      foreach (mq[i]) begin
         if (mq[i].a[31:2] == ld_addr[31:2]) begin
            hit  = 1'b1;
            data = mq[i].d;
         end
      end
      chk("ld_hit", 32'(ld_hit), 32'(hit));
      chk("ld_data", ld_data, data);
   endtask

   // one clock cycle of stimulus, checking, and model update
   task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic mr, input logic [31:0] la);
      bit do_push;
      bit do_pop;
      @(negedge clk);
      st_valid  = sv;
      st_addr   = sa;
      st_data   = sd;
      mem_ready = mr;
      ld_addr   = la;
      #2;
      check_state();
      do_push = sv && (mq.size() < DEPTH);
      do_pop  = mr && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         mq.push_back('{a: sa, d: sd});
         exp_q.push_back({sa, sd});
      end
   endtask

   // reset asserted between clock edges; outputs must clear at once
   task automatic reset_mid();
      @(negedge clk);
      st_valid  = 1'b0;
      mem_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_st_ready", 32'(st_ready), 32'd1);
      chk("rst_ld_hit", 32'(ld_hit), 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      mq.delete();
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // monitor: every accepted memory write must be the next expected store
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (reset && mem_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL drain_unexpected: got %h/%h expected nothing", mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("drain_addr", mem_addr, e[63:32]);
               chk("drain_data", mem_wdata, e[31:0]);
            end
         end
      end
   end

   initial begin
      logic [31:0] a;
      reset     = 1'b0;
      st_valid  = 1'b0;
      st_addr   = '0;
      st_data   = '0;
      mem_ready = 1'b0;
      ld_addr   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // idle after reset, then reset mid-cycle with data pending
      cycle(0, 0, 0, 0, 32'h0);
      cycle(1, 32'h40, 32'h1234, 0, 32'h40);
      cycle(0, 0, 0, 0, 32'h40);
      reset_mid();

      // single store presented and held while memory stalls
      cycle(1, 32'h100, 32'hAAAA_AAAA, 0, 32'h0);
      repeat (5) cycle(0, 0, 0, 0, 32'h100);
      repeat (2) cycle(0, 0, 0, 1, 32'h0);

      // fill, hold a 5th store while full, then one pop admits it
      for (int i = 0; i < 4; i++) cycle(1, 32'h500 + 32'(i * 4), 32'hC000 + 32'(i), 0, 32'h504);
      cycle(1, 32'h510, 32'hC004, 0, 32'h510);
      cycle(1, 32'h510, 32'hC004, 0, 32'h510);
      cycle(1, 32'h510, 32'hC004, 1, 32'h510);
      cycle(1, 32'h510, 32'hC004, 0, 32'h510);
      cycle(0, 0, 0, 0, 32'h510);
      repeat (6) cycle(0, 0, 0, 1, 32'h500);

      // youngest match wins; byte offset ignored; neighbour word misses
      cycle(1, 32'h200, 32'h1, 0, 32'h200);
      cycle(1, 32'h200, 32'h2, 0, 32'h200);
      cycle(0, 0, 0, 0, 32'h200);
      cycle(0, 0, 0, 0, 32'h203);
      cycle(0, 0, 0, 0, 32'h204);
      repeat (3) cycle(0, 0, 0, 1, 32'h200);

      // steady push+pop at count 2, pointers wrap twice
      cycle(1, 32'h600, 32'hD000, 0, 32'h600);
      cycle(1, 32'h604, 32'hD001, 0, 32'h600);
      for (int i = 2; i < 10; i++) cycle(1, 32'h600 + 32'(i * 4), 32'hD000 + 32'(i), 1, 32'h600 + 32'(i * 4));
      cycle(0, 0, 0, 0, 32'h624);

      // three buffered, reset drops them; former address no longer hits
      for (int i = 0; i < 3; i++) cycle(1, 32'h700 + 32'(i * 4), 32'hE000 + 32'(i), 0, 32'h700);
      cycle(0, 0, 0, 0, 32'h704);
      reset_mid();
      cycle(0, 0, 0, 0, 32'h704);

      // random traffic over a small address window
      repeat (400) begin
         a = 32'h300 + (32'($urandom_range(0, 7)) << 2);
         cycle(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 2) != 0),
               32'h300 + 32'($urandom_range(0, 31)));
      end

      // bounded drain
      for (int i = 0; i < 20 && mq.size() > 0; i++) cycle(0, 0, 0, 1, 32'h300);
      cycle(0, 0, 0, 0, 32'h300);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
